// File: rtl/rmw_long_latency_ooo_pkg.sv
// Shared types for the read-modify-write engine: command opcodes, entry states,
// accumulation mode and the per-entry control record.
package rmw_long_latency_ooo_pkg;

    localparam int DEF_ID_W = 16;
    localparam int DEF_W    = 32;
    localparam int DEF_N    = 16;

    typedef enum logic [1:0] {
        OP_NOP  = 2'd0,
        OP_ADDI = 2'd1,
        OP_SUBI = 2'd2,
        OP_MOVI = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_REQ  = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_WR_REQ  = 2'd3
    } state_t;

    typedef enum logic {
        MODE_REL = 1'b0,
        MODE_ABS = 1'b1
    } mode_t;

    // id and acc are parameter-sized, so they are stored beside this record
    typedef struct packed {
        state_t state;
        mode_t  mode;
    } entry_t;

endpackage

// File: rtl/rmw_long_latency_ooo_if.sv
// Command, read, response and write channels of the RMW engine.
interface rmw_long_latency_ooo_if
    import rmw_long_latency_ooo_pkg::*;
#(
    parameter int ID_W  = DEF_ID_W,
    parameter int W     = DEF_W,
    parameter int TAG_W = $clog2(DEF_N)
);
    logic             in_vld;
    op_t              in_op;
    logic [W-1:0]     in_imm;
    logic [ID_W-1:0]  in_id;
    logic             in_accept;
    logic             rd_vld;
    logic [ID_W-1:0]  rd_id;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_rdy;
    logic             rsp_vld;
    logic [TAG_W-1:0] rsp_tag;
    logic [W-1:0]     rsp_data;
    logic             wr_vld;
    logic [ID_W-1:0]  wr_id;
    logic [W-1:0]     wr_data;
    logic             wr_rdy;
    logic             busy;

    modport master (
        output in_vld, in_op, in_imm, in_id, rd_rdy, rsp_vld, rsp_tag, rsp_data, wr_rdy,
        input  in_accept, rd_vld, rd_id, rd_tag, wr_vld, wr_id, wr_data, busy
    );

    modport slave (
        input  in_vld, in_op, in_imm, in_id, rd_rdy, rsp_vld, rsp_tag, rsp_data, wr_rdy,
        output in_accept, rd_vld, rd_id, rd_tag, wr_vld, wr_id, wr_data, busy
    );
endinterface

// File: rtl/rmw_long_latency_ooo_pri.sv
// Lowest-index priority encoder with an any-set flag.
module rmw_long_latency_ooo_pri #(
    parameter  int N     = 16,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);
    // scan downwards so the lowest set bit is the last one written
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
                any_o = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rmw_long_latency_ooo.sv
// Out-of-order read-modify-write engine coalescing commands per id into N entries.
// Optional RMW_LONG_LATENCY_OOO_MOVI_BYPASS_EN: an allocating MOVI skips the read.
module rmw_long_latency_ooo
    import rmw_long_latency_ooo_pkg::*;
#(
    parameter int ID_W = DEF_ID_W,
    parameter int W    = DEF_W,
    parameter int N    = DEF_N
) (
    input logic                  clk,
    input logic                  rst_n,
    rmw_long_latency_ooo_if.slave bus
);
    localparam int TAG_W = $clog2(N);

    entry_t          ctl_q [N];
    entry_t          ctl_d [N];
    logic [ID_W-1:0] id_q  [N];
    logic [ID_W-1:0] id_d  [N];
    logic [W-1:0]    acc_q [N];
    logic [W-1:0]    acc_d [N];

    logic [N-1:0]     idle_s, rdreq_s, wrreq_s, match_s;
    logic [TAG_W-1:0] match_idx_s, alloc_idx_s, rd_idx_s, wr_idx_s;
    logic             match_any_s, match_wr_s, alloc_any_s, rd_any_s, wr_any_s;
    logic             fold_en_s, rd_fire_s, wr_fire_s;

    function automatic logic [W-1:0] fold_acc(input logic [W-1:0] acc, input op_t op,
                                              input logic [W-1:0] imm);
        logic [W-1:0] res;
        case (op)
            OP_ADDI: res = acc + imm;
            OP_SUBI: res = acc - imm;
            OP_MOVI: res = imm;
            default: res = acc;
        endcase
        return res;
    endfunction

    // per-entry state decode and id match against the incoming command
    always_comb begin
        match_idx_s = '0;
        for (int i = 0; i < N; i++) begin
            idle_s[i]  = (ctl_q[i].state == ST_IDLE);
            rdreq_s[i] = (ctl_q[i].state == ST_RD_REQ);
            wrreq_s[i] = (ctl_q[i].state == ST_WR_REQ);
            match_s[i] = !idle_s[i] && (id_q[i] == bus.in_id);
            if (match_s[i]) begin
                match_idx_s = TAG_W'(i);
            end
        end
    end

    assign match_any_s = |match_s;
    assign match_wr_s  = |(match_s & wrreq_s);

    rmw_long_latency_ooo_pri #(.N(N)) u_alloc (.req_i(idle_s),  .idx_o(alloc_idx_s), .any_o(alloc_any_s));
    rmw_long_latency_ooo_pri #(.N(N)) u_rdsel (.req_i(rdreq_s), .idx_o(rd_idx_s),    .any_o(rd_any_s));
    rmw_long_latency_ooo_pri #(.N(N)) u_wrsel (.req_i(wrreq_s), .idx_o(wr_idx_s),    .any_o(wr_any_s));

    // an id in WR_REQ stalls until its write leaves, so a later read sees the new data
    assign bus.in_accept = rst_n && bus.in_vld &&
                           ((bus.in_op == OP_NOP) || (match_any_s ? !match_wr_s : alloc_any_s));
    assign fold_en_s     = bus.in_accept && (bus.in_op != OP_NOP);
    assign rd_fire_s     = rd_any_s && bus.rd_rdy;
    assign wr_fire_s     = wr_any_s && bus.wr_rdy;

    assign bus.rd_vld  = rd_any_s;
    assign bus.rd_id   = rd_any_s ? id_q[rd_idx_s] : '0;
    assign bus.rd_tag  = rd_any_s ? rd_idx_s : '0;
    assign bus.wr_vld  = wr_any_s;
    assign bus.wr_id   = wr_any_s ? id_q[wr_idx_s] : '0;
    assign bus.wr_data = wr_any_s ? acc_q[wr_idx_s] : '0;
    assign bus.busy    = !(&idle_s);

    // entry next state: handshakes and response first, then the command fold on top
    always_comb begin
        ctl_d = ctl_q;
        id_d  = id_q;
        acc_d = acc_q;
        for (int i = 0; i < N; i++) begin
            if (rd_fire_s && (rd_idx_s == TAG_W'(i))) begin
                ctl_d[i].state = ST_RD_WAIT;
            end
            if (bus.rsp_vld && (bus.rsp_tag == TAG_W'(i)) && (ctl_q[i].state == ST_RD_WAIT)) begin
                acc_d[i]       = (ctl_q[i].mode == MODE_REL) ? (bus.rsp_data + acc_q[i]) : acc_q[i];
                ctl_d[i].state = ST_WR_REQ;
            end
            if (wr_fire_s && (wr_idx_s == TAG_W'(i))) begin
                ctl_d[i].state = ST_IDLE;
            end
            if (fold_en_s && match_any_s && (match_idx_s == TAG_W'(i))) begin
                acc_d[i] = fold_acc(acc_d[i], bus.in_op, bus.in_imm);
                if (bus.in_op == OP_MOVI) begin
                    ctl_d[i].mode = MODE_ABS;
                end else begin
                    ctl_d[i].mode = ctl_q[i].mode;
                end
            end else if (fold_en_s && !match_any_s && (alloc_idx_s == TAG_W'(i))) begin
                id_d[i]       = bus.in_id;
                acc_d[i]      = fold_acc('0, bus.in_op, bus.in_imm);
                ctl_d[i].mode = (bus.in_op == OP_MOVI) ? MODE_ABS : MODE_REL;
`ifdef RMW_LONG_LATENCY_OOO_MOVI_BYPASS_EN
                ctl_d[i].state = (bus.in_op == OP_MOVI) ? ST_WR_REQ : ST_RD_REQ;
`else
                ctl_d[i].state = ST_RD_REQ;
`endif
            end else begin
                id_d[i] = id_q[i];
            end
        end
    end

    // entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                ctl_q[i] <= '{state: ST_IDLE, mode: MODE_REL};
                id_q[i]  <= '0;
                acc_q[i] <= '0;
            end
        end else begin
            ctl_q <= ctl_d;
            id_q  <= id_d;
            acc_q <= acc_d;
        end
    end
endmodule

// File: tb/tb_rmw_long_latency_ooo.sv
// Directed bench for rmw_long_latency_ooo; honours RMW_LONG_LATENCY_OOO_MOVI_BYPASS_EN.
module tb_rmw_long_latency_ooo;
    import rmw_long_latency_ooo_pkg::*;

    localparam int N     = 16;
    localparam int ID_W  = 16;
    localparam int W     = 32;
    localparam int TAG_W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   rd_hs   = 0;
    int   wr_hs   = 0;

    always #5 clk = ~clk;

    rmw_long_latency_ooo_if #(.ID_W(ID_W), .W(W), .TAG_W(TAG_W)) bus ();

    rmw_long_latency_ooo #(.ID_W(ID_W), .W(W), .N(N)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always @(posedge clk) begin
        if (bus.rd_vld && bus.rd_rdy) rd_hs <= rd_hs + 1;
        if (bus.wr_vld && bus.wr_rdy) wr_hs <= wr_hs + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        bus.in_vld   = 1'b0;
        bus.in_op    = OP_NOP;
        bus.in_imm   = 32'd0;
        bus.in_id    = 16'd0;
        bus.rd_rdy   = 1'b0;
        bus.rsp_vld  = 1'b0;
        bus.rsp_tag  = 4'd0;
        bus.rsp_data = 32'd0;
        bus.wr_rdy   = 1'b0;
    endtask

    task automatic cmd(input op_t op, input logic [15:0] id, input logic [31:0] imm);
        bus.in_vld = 1'b1;
        bus.in_op  = op;
        bus.in_id  = id;
        bus.in_imm = imm;
        #1;
    endtask

    task automatic rsp(input logic [3:0] tag, input logic [31:0] data);
        bus.rsp_vld  = 1'b1;
        bus.rsp_tag  = tag;
        bus.rsp_data = data;
        tick();
        bus.rsp_vld  = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        quiet();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        quiet();
        rst_n = 1'b0;
        tick();
        vec_cnt++;
        if ({bus.rd_vld, bus.wr_vld, bus.busy, bus.in_accept} !== 4'b0000) begin
            err_cnt++;
            $display("FAIL reset_flags: got %b want 0000", {bus.rd_vld, bus.wr_vld, bus.busy, bus.in_accept});
        end
        vec_cnt++;
        if ({bus.rd_id, bus.rd_tag, bus.wr_id, bus.wr_data} !== 68'd0) begin
            err_cnt++;
            $display("FAIL reset_busses: got %h want 0", {bus.rd_id, bus.rd_tag, bus.wr_id, bus.wr_data});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_addi();
        cmd(OP_ADDI, 16'd5, 32'd3);
        vec_cnt++;
        if (bus.in_accept !== 1'b1) begin
            err_cnt++; $display("FAIL addi_accept: got %b want 1", bus.in_accept);
        end
        tick();
        quiet();
        vec_cnt++;
        if ({bus.rd_vld, bus.rd_id, bus.rd_tag} !== {1'b1, 16'd5, 4'd0}) begin
            err_cnt++; $display("FAIL addi_read: got %h want %h", {bus.rd_vld, bus.rd_id, bus.rd_tag}, {1'b1, 16'd5, 4'd0});
        end
        bus.rd_rdy = 1'b1;
        tick();
        bus.rd_rdy = 1'b0;
        vec_cnt++;
        if ({bus.rd_vld, bus.busy} !== 2'b01) begin
            err_cnt++; $display("FAIL addi_rdwait: got %b want 01", {bus.rd_vld, bus.busy});
        end
        rsp(4'd0, 32'd10);
        vec_cnt++;
        if ({bus.wr_vld, bus.wr_id, bus.wr_data} !== {1'b1, 16'd5, 32'd13}) begin
            err_cnt++; $display("FAIL addi_write: got %h want %h", {bus.wr_vld, bus.wr_id, bus.wr_data}, {1'b1, 16'd5, 32'd13});
        end
        bus.wr_rdy = 1'b1;
        tick();
        bus.wr_rdy = 1'b0;
        vec_cnt++;
        if ({bus.wr_vld, bus.busy} !== 2'b00) begin
            err_cnt++; $display("FAIL addi_idle: got %b want 00", {bus.wr_vld, bus.busy});
        end
    endtask

    task automatic test_coalesce();
        int r0, w0;
        r0 = rd_hs;
        w0 = wr_hs;
        cmd(OP_ADDI, 16'd5, 32'd3);
        tick();
        cmd(OP_SUBI, 16'd5, 32'd1);
        vec_cnt++;
        if (bus.in_accept !== 1'b1) begin
            err_cnt++; $display("FAIL coal_fold_rdreq: got %b want 1", bus.in_accept);
        end
        tick();
        cmd(OP_ADDI, 16'd5, 32'd7);
        bus.rd_rdy = 1'b1;
        vec_cnt++;
        if (bus.in_accept !== 1'b1) begin
            err_cnt++; $display("FAIL coal_fold_rdfire: got %b want 1", bus.in_accept);
        end
        tick();
        quiet();
        rsp(4'd0, 32'd100);
        vec_cnt++;
        if ({bus.wr_vld, bus.wr_id, bus.wr_data} !== {1'b1, 16'd5, 32'd109}) begin
            err_cnt++; $display("FAIL coal_write: got %h want %h", {bus.wr_vld, bus.wr_id, bus.wr_data}, {1'b1, 16'd5, 32'd109});
        end
        bus.wr_rdy = 1'b1;
        tick();
        quiet();
        vec_cnt++;
        if ((rd_hs - r0) != 1 || (wr_hs - w0) != 1 || bus.busy !== 1'b0) begin
            err_cnt++; $display("FAIL coal_counts: got rd=%0d wr=%0d busy=%b want rd=1 wr=1 busy=0", rd_hs - r0, wr_hs - w0, bus.busy);
        end
    endtask

    task automatic test_movi();
        int r0;
        r0 = rd_hs;
        cmd(OP_MOVI, 16'd9, 32'h55);
        tick();
        quiet();
`ifdef RMW_LONG_LATENCY_OOO_MOVI_BYPASS_EN
        vec_cnt++;
        if ({bus.rd_vld, bus.wr_vld, bus.wr_id, bus.wr_data} !== {1'b0, 1'b1, 16'd9, 32'h55}) begin
            err_cnt++; $display("FAIL movi_bypass: got %h want %h", {bus.rd_vld, bus.wr_vld, bus.wr_id, bus.wr_data}, {1'b0, 1'b1, 16'd9, 32'h55});
        end
`else
        vec_cnt++;
        if ({bus.rd_vld, bus.rd_id, bus.wr_vld} !== {1'b1, 16'd9, 1'b0}) begin
            err_cnt++; $display("FAIL movi_read: got %h want %h", {bus.rd_vld, bus.rd_id, bus.wr_vld}, {1'b1, 16'd9, 1'b0});
        end
        bus.rd_rdy = 1'b1;
        tick();
        bus.rd_rdy = 1'b0;
        rsp(4'd0, 32'hFFFF_FFFF);
        vec_cnt++;
        if ({bus.wr_vld, bus.wr_id, bus.wr_data} !== {1'b1, 16'd9, 32'h55}) begin
            err_cnt++; $display("FAIL movi_write: got %h want %h", {bus.wr_vld, bus.wr_id, bus.wr_data}, {1'b1, 16'd9, 32'h55});
        end
        r0 = r0 + 1;
`endif
        bus.wr_rdy = 1'b1;
        tick();
        quiet();
        vec_cnt++;
        if ((rd_hs != r0) || bus.busy !== 1'b0) begin
            err_cnt++; $display("FAIL movi_reads: got rd=%0d busy=%b want rd=%0d busy=0", rd_hs, bus.busy, r0);
        end
    endtask

    task automatic test_full();
        int bad;
        bad = 0;
        for (int i = 0; i < N; i++) begin
            cmd(OP_ADDI, 16'(100 + i), 32'(i));
            if (bus.in_accept !== 1'b1) bad++;
            tick();
        end
        vec_cnt++;
        if (bad != 0) begin
            err_cnt++; $display("FAIL full_fill: got %0d rejects want 0", bad);
        end
        cmd(OP_ADDI, 16'd200, 32'd1);
        vec_cnt++;
        if (bus.in_accept !== 1'b0) begin
            err_cnt++; $display("FAIL full_reject: got %b want 0", bus.in_accept);
        end
        bus.rd_rdy = 1'b1;
        repeat (4) tick();
        vec_cnt++;
        if ({bus.in_accept, bus.rd_tag} !== {1'b0, 4'd4}) begin
            err_cnt++; $display("FAIL full_reads: got %h want %h", {bus.in_accept, bus.rd_tag}, {1'b0, 4'd4});
        end
        bus.rd_rdy = 1'b0;
        rsp(4'd3, 32'd0);
        vec_cnt++;
        if ({bus.wr_vld, bus.wr_id, bus.wr_data, bus.in_accept} !== {1'b1, 16'd103, 32'd3, 1'b0}) begin
            err_cnt++; $display("FAIL full_write: got %h want %h", {bus.wr_vld, bus.wr_id, bus.wr_data, bus.in_accept}, {1'b1, 16'd103, 32'd3, 1'b0});
        end
        bus.wr_rdy = 1'b1;
        tick();
        bus.wr_rdy = 1'b0;
        #1;
        vec_cnt++;
        if (bus.in_accept !== 1'b1) begin
            err_cnt++; $display("FAIL full_freed_accept: got %b want 1", bus.in_accept);
        end
        tick();
        quiet();
        vec_cnt++;
        if ({bus.rd_vld, bus.rd_id, bus.rd_tag} !== {1'b1, 16'd200, 4'd3}) begin
            err_cnt++; $display("FAIL full_reuse: got %h want %h", {bus.rd_vld, bus.rd_id, bus.rd_tag}, {1'b1, 16'd200, 4'd3});
        end
        do_reset();
    endtask

    task automatic test_ooo();
        int r0;
        r0 = rd_hs;
        bus.rd_rdy = 1'b1;
        cmd(OP_ADDI, 16'd20, 32'd1);
        tick();
        cmd(OP_ADDI, 16'd21, 32'd2);
        tick();
        cmd(OP_SUBI, 16'd22, 32'd1);
        tick();
        bus.in_vld = 1'b0;
        tick();
        bus.rd_rdy = 1'b0;
        vec_cnt++;
        if (bus.rd_vld !== 1'b0 || (rd_hs - r0) != 3) begin
            err_cnt++; $display("FAIL ooo_reads: got vld=%b n=%0d want vld=0 n=3", bus.rd_vld, rd_hs - r0);
        end
        rsp(4'd2, 32'd2);
        vec_cnt++;
        if ({bus.wr_vld, bus.wr_id, bus.wr_data} !== {1'b1, 16'd22, 32'd1}) begin
            err_cnt++; $display("FAIL ooo_wrap: got %h want %h", {bus.wr_vld, bus.wr_id, bus.wr_data}, {1'b1, 16'd22, 32'd1});
        end
        rsp(4'd0, 32'd10);
        vec_cnt++;
        if ({bus.wr_id, bus.wr_data} !== {16'd20, 32'd11}) begin
            err_cnt++; $display("FAIL ooo_prio: got %h want %h", {bus.wr_id, bus.wr_data}, {16'd20, 32'd11});
        end
        rsp(4'd1, 32'd5);
        vec_cnt++;
        if ({bus.wr_id, bus.wr_data} !== {16'd20, 32'd11}) begin
            err_cnt++; $display("FAIL ooo_hold: got %h want %h", {bus.wr_id, bus.wr_data}, {16'd20, 32'd11});
        end
        bus.wr_rdy = 1'b1;
        tick();
        vec_cnt++;
        if ({bus.wr_id, bus.wr_data} !== {16'd21, 32'd7}) begin
            err_cnt++; $display("FAIL ooo_second: got %h want %h", {bus.wr_id, bus.wr_data}, {16'd21, 32'd7});
        end
        tick();
        vec_cnt++;
        if ({bus.wr_id, bus.wr_data} !== {16'd22, 32'd1}) begin
            err_cnt++; $display("FAIL ooo_third: got %h want %h", {bus.wr_id, bus.wr_data}, {16'd22, 32'd1});
        end
        tick();
        bus.wr_rdy = 1'b0;
        rsp(4'd1, 32'd9);
        vec_cnt++;
        if ({bus.busy, bus.wr_vld} !== 2'b00) begin
            err_cnt++; $display("FAIL ooo_stale: got %b want 00", {bus.busy, bus.wr_vld});
        end
    endtask

    task automatic test_stall_reset();
        bus.rd_rdy = 1'b1;
        cmd(OP_ADDI, 16'd7, 32'd4);
        tick();
        bus.in_vld = 1'b0;
        tick();
        bus.rd_rdy = 1'b0;
        rsp(4'd0, 32'd1);
        cmd(OP_ADDI, 16'd7, 32'd1);
        vec_cnt++;
        if ({bus.in_accept, bus.wr_vld, bus.wr_data} !== {1'b0, 1'b1, 32'd5}) begin
            err_cnt++; $display("FAIL stall_first: got %h want %h", {bus.in_accept, bus.wr_vld, bus.wr_data}, {1'b0, 1'b1, 32'd5});
        end
        tick();
        vec_cnt++;
        if ({bus.in_accept, bus.wr_vld, bus.wr_id, bus.wr_data} !== {1'b0, 1'b1, 16'd7, 32'd5}) begin
            err_cnt++; $display("FAIL stall_hold: got %h want %h", {bus.in_accept, bus.wr_vld, bus.wr_id, bus.wr_data}, {1'b0, 1'b1, 16'd7, 32'd5});
        end
        rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({bus.rd_vld, bus.wr_vld, bus.busy, bus.in_accept, bus.rd_id, bus.rd_tag, bus.wr_id, bus.wr_data} !== 72'd0) begin
            err_cnt++; $display("FAIL midrst_outputs: got %h want 0", {bus.rd_vld, bus.wr_vld, bus.busy, bus.in_accept, bus.rd_id, bus.rd_tag, bus.wr_id, bus.wr_data});
        end
        tick();
        rst_n = 1'b1;
        bus.in_vld = 1'b0;
        rsp(4'd0, 32'd3);
        vec_cnt++;
        if ({bus.busy, bus.wr_vld, bus.rd_vld} !== 3'b000) begin
            err_cnt++; $display("FAIL midrst_stale: got %b want 000", {bus.busy, bus.wr_vld, bus.rd_vld});
        end
        cmd(OP_ADDI, 16'd7, 32'd1);
        vec_cnt++;
        if (bus.in_accept !== 1'b1) begin
            err_cnt++; $display("FAIL midrst_accept: got %b want 1", bus.in_accept);
        end
        tick();
        quiet();
        vec_cnt++;
        if ({bus.rd_vld, bus.rd_id, bus.rd_tag} !== {1'b1, 16'd7, 4'd0}) begin
            err_cnt++; $display("FAIL midrst_realloc: got %h want %h", {bus.rd_vld, bus.rd_id, bus.rd_tag}, {1'b1, 16'd7, 4'd0});
        end
    endtask

    initial begin
        quiet();
        test_reset();
        test_addi();
        test_coalesce();
        test_movi();
        test_full();
        test_ooo();
        test_stall_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/rmw_long_latency_ooo.md
# rmw_long_latency_ooo

Parametrised out-of-order read-modify-write engine for long-latency memories. It accepts ADDI/SUBI/MOVI/NOP commands against a word addressed by `id` and tracks up to `N` distinct ids in flight. Commands to an id already in flight are coalesced into its entry, so each id issues only one read and one write. The block sits between the command source and a tagged, out-of-order-response memory port.

## Interface
- `ID_W`, 16: id width.
- `W`, 32: data word width.
- `N`, 16: entry count; power of two, minimum 2.
- `TAG_W`, `$clog2(N)`: tag width. Derived; not overridden.

- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_vld`  in  1  command valid.
- `in_op`  in  2  `op_t`: NOP=0, ADDI=1, SUBI=2, MOVI=3.
- `in_imm`  in  W  immediate.
- `in_id`  in  ID_W  target id.
- `in_accept`  out  1  command taken this cycle. Combinational.
- `rd_vld`  out  1  read request valid.
- `rd_id`  out  ID_W  read id.
- `rd_tag`  out  TAG_W  entry index.
- `rd_rdy`  in  1  memory accepts the read.
- `rsp_vld`  in  1  read response valid. Always accepted.
- `rsp_tag`  in  TAG_W  response tag.
- `rsp_data`  in  W  read data.
- `wr_vld`  out  1  write valid.
- `wr_id`  out  ID_W  write id.
- `wr_data`  out  W  write data.
- `wr_rdy`  in  1  memory accepts the write.
- `busy`  out  1  at least one entry is not IDLE.

## Operation
- Entry fields: state, id, mode (REL/ABS), acc (W bits).
- Entry states: IDLE, RD_REQ, RD_WAIT, WR_REQ.
- Fold rule:
  - REL mode: ADDI gives acc+=imm; SUBI gives acc-=imm.
  - MOVI gives mode=ABS, acc=imm.
  - ABS mode: ADDI/SUBI update acc the same way.
  - All arithmetic is modulo 2^W.
- NOP: accepted whenever `in_vld`; no state change.
- Match is against entries that are not IDLE with the same id. At most one entry matches.
  - Match in RD_REQ or RD_WAIT: fold into that entry. `in_accept`=1.
  - Match in WR_REQ: `in_accept`=0 until the write handshake completes.
- No match: allocate the lowest-index IDLE entry with mode=REL, acc=0, then fold, state→RD_REQ. If no entry is IDLE, `in_accept`=0.
- Read: the lowest-index RD_REQ entry drives `rd_*`. On handshake, state→RD_WAIT.
- Response for an entry in RD_WAIT:
  - REL mode: acc = rsp_data + acc.
  - ABS mode: acc unchanged and the data is discarded.
  - state→WR_REQ.
- Response with a tag whose entry is not in RD_WAIT is ignored.
- Response and fold to the same entry in the same cycle: the fold applies on top of the response result.
- Write: the lowest-index WR_REQ entry drives `wr_*` with wr_data=acc. On handshake, state→IDLE.
- Memory contract: a read accepted after a write to the same id returns the written data.

## Timing
- Reset values: `rd_vld`, `wr_vld`, `busy`, `in_accept` = 0. All `*_id`, `*_tag` and `*_data` outputs = 0. All entries are IDLE.
- Latency: command accepted at cycle T gives `rd_vld` at T+1 at the earliest. A response at cycle R gives `wr_vld` at R+1.
- A freed entry can be allocated in the cycle after its write handshake.
- `rd_*` and `wr_*` hold stable while valid and not ready, unless a higher-priority entry becomes eligible. Valid is never dropped without a handshake.
- Reset asserted mid-operation: all entries are dropped and the pending reads/writes are lost. Stale responses after reset are ignored.

## Configuration
- `RMW_LONG_LATENCY_OOO_MOVI_BYPASS_EN`
  - Defined: a MOVI that allocates a new entry goes straight to WR_REQ with acc=imm. No read is issued.
  - Undefined: the entry follows the normal RD_REQ path in ABS mode and the response data is discarded.

## Structure
- Shared package `rmw_long_latency_ooo_pkg` contains:
  - `op_t`
  - state enum `state_t`
  - mode enum
  - entry struct
  - default-parameter localparams
- Sub-module `rmw_long_latency_ooo_pri`: N-bit lowest-index priority encoder with any-set output. It is instantiated three times, for allocate, read select and write select.

## Test plan
- ADDI id=5 imm=3, then rsp data=10 → one read (tag 0), then write id=5 data=13.
- ADDI 5/3, SUBI 5/1, ADDI 5/7 before the response, then rsp=100 → exactly one read and one write, data=109.
- MOVI id=9 imm=0x55 → bypass defined: no read, write 0x55 at T+1. Bypass undefined: read issued, rsp=0xFFFF_FFFF, write 0x55.
- Fill all N entries with distinct ids, then send an (N+1)th new id → `in_accept`=0 until a write completes. The new entry is accepted the cycle after and takes the freed index.
- Out-of-order responses with tags 2, 0, 1 → writes issue in ready order by lowest index. Data wraps: acc=0xFFFF_FFFF + rsp 2 gives write 1.
- Hold `wr_rdy`=0 with id 7 in WR_REQ and send ADDI 7 → stalled. Pulse `rst_n` low mid-test → all outputs go to 0 and `busy`=0.
